// File: rtl/mem_arbiter_if.sv
// Request/grant/read-return bundle between the CPU and VGA requesters, the arbiter
// and the shared single-port memory.
interface mem_arbiter_if;
  // Handshake: a requester holds req/addr (and write/wdata) until it sees gnt high in
  // the same cycle; a granted read returns rdata qualified by rvalid exactly one cycle
  // after the grant. Requests that are not granted are neither dropped nor queued.
  logic        cpu_req;
  logic [15:0] cpu_addr;
  logic        cpu_write;
  logic [15:0] cpu_wdata;
  logic        cpu_gnt;
  logic        cpu_rvalid;
  logic [15:0] cpu_rdata;

  logic        vga_req;
  logic [15:0] vga_addr;
  logic        vga_gnt;
  logic        vga_rvalid;
  logic [15:0] vga_rdata;

  logic [15:0] mem_addr;
  logic        mem_write;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_addr, cpu_write, cpu_wdata, vga_req, vga_addr, mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_addr, mem_write, mem_wdata
  );

  modport master (
    output cpu_req, cpu_addr, cpu_write, cpu_wdata, vga_req, vga_addr, mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata, vga_gnt, vga_rvalid, vga_rdata,
           mem_addr, mem_write, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port arbiter for a shared single-port memory: VGA is favoured, but the CPU
// wins after MAX_BURST consecutive contended VGA grants. Reads return one cycle later.
module mem_arbiter #(
  parameter int unsigned MAX_BURST = 8
) (
  input  logic              clk,
  input  logic              rst,
  mem_arbiter_if.slave      bus,
  output logic [3:0]        dbg_streak,
  output logic [1:0]        dbg_tag
);

  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_CPU  = 2'd1,
    TAG_VGA  = 2'd2
  } tag_t;

  localparam logic [3:0] BURST_LIMIT = 4'(MAX_BURST);

  logic [3:0] streak;
  tag_t       tag;
  logic       contended;
  logic       cpu_win;
  logic       vga_win;

  assign contended = bus.cpu_req && bus.vga_req;

  // Grants are forced low while reset is held so no write can slip through.
  always_comb begin
    cpu_win = 1'b0;
    vga_win = 1'b0;
    if (!rst) begin
      if (contended) begin
        if (streak < BURST_LIMIT) vga_win = 1'b1;
        else                      cpu_win = 1'b1;
      end else begin
        cpu_win = bus.cpu_req;
        vga_win = bus.vga_req;
      end
    end
  end

  // Streak only grows while both contend and VGA keeps winning, so it can reach
  // BURST_LIMIT but never pass it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      streak <= 4'd0;
      tag    <= TAG_NONE;
    end else begin
      if (contended && vga_win) streak <= streak + 4'd1;
      else                      streak <= 4'd0;

      if (vga_win)                         tag <= TAG_VGA;
      else if (cpu_win && !bus.cpu_write)  tag <= TAG_CPU;
      else                                 tag <= TAG_NONE;
    end
  end

  assign bus.cpu_gnt    = cpu_win;
  assign bus.vga_gnt    = vga_win;
  assign bus.mem_addr   = vga_win ? bus.vga_addr : bus.cpu_addr;
  assign bus.mem_write  = cpu_win && bus.cpu_write;
  assign bus.mem_wdata  = bus.cpu_wdata;

  assign bus.cpu_rvalid = (tag == TAG_CPU);
  assign bus.vga_rvalid = (tag == TAG_VGA);
  assign bus.cpu_rdata  = bus.mem_rdata;
  assign bus.vga_rdata  = bus.mem_rdata;

  assign dbg_streak = streak;
  assign dbg_tag    = tag;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized and directed bench for mem_arbiter with a behavioural arbitration and
// memory model; expected read returns are queued and checked by a negedge monitor.
module tb_mem_arbiter;
  localparam int unsigned MAX_BURST = 8;
  localparam int W = 48;  // {due_cycle[31:0], data[15:0]}

  logic       clk;
  logic       rst;
  logic [3:0] dbg_streak;
  logic [1:0] dbg_tag;

  mem_arbiter_if bus ();

  mem_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .dbg_streak (dbg_streak),
    .dbg_tag    (dbg_tag)
  );

  // ---------------- clock / reset / cycle count ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [W-1:0] cpu_q[$];
  logic [W-1:0] vga_q[$];
  logic [15:0]  ref_mem[int];
  logic [15:0]  env_mem[int];
  int unsigned  m_streak = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] init_pat(input logic [15:0] a);
    if (a == 16'h0040) return 16'hBEEF;
    return {a[7:0], a[15:8]} ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] ref_read(input logic [15:0] a);
    if (ref_mem.exists(int'(a))) return ref_mem[int'(a)];
    return init_pat(a);
  endfunction

  // ---------------- memory environment (one-cycle read latency) ----------------
  initial forever begin
    @(posedge clk);
    if (bus.mem_write) env_mem[int'(bus.mem_addr)] = bus.mem_wdata;
    bus.mem_rdata <= env_mem.exists(int'(bus.mem_addr)) ? env_mem[int'(bus.mem_addr)]
                                                         : init_pat(bus.mem_addr);
  end

  // ---------------- monitor + reference model ----------------
  initial begin
    logic [W-1:0] e;
    int           own;  // 0 none, 1 cpu, 2 vga
    forever begin
      @(negedge clk);
      if (rst) begin
        cpu_q.delete();
        vga_q.delete();
        m_streak = 0;
        chk("rst_cpu_gnt",    32'(bus.cpu_gnt),    0);
        chk("rst_vga_gnt",    32'(bus.vga_gnt),    0);
        chk("rst_cpu_rvalid", 32'(bus.cpu_rvalid), 0);
        chk("rst_vga_rvalid", 32'(bus.vga_rvalid), 0);
        chk("rst_mem_write",  32'(bus.mem_write),  0);
        chk("rst_streak",     32'(dbg_streak),     0);
      end else begin
        if (cpu_q.size() > 0 && cpu_q[0][47:16] == 32'(cyc)) begin
          e = cpu_q.pop_front();
          chk("cpu_rvalid", 32'(bus.cpu_rvalid), 1);
          chk("cpu_rdata",  32'(bus.cpu_rdata),  32'(e[15:0]));
        end else begin
          chk("cpu_rvalid_idle", 32'(bus.cpu_rvalid), 0);
        end
        if (vga_q.size() > 0 && vga_q[0][47:16] == 32'(cyc)) begin
          e = vga_q.pop_front();
          chk("vga_rvalid", 32'(bus.vga_rvalid), 1);
          chk("vga_rdata",  32'(bus.vga_rdata),  32'(e[15:0]));
        end else begin
          chk("vga_rvalid_idle", 32'(bus.vga_rvalid), 0);
        end

        if (bus.cpu_req && bus.vga_req) own = (m_streak < MAX_BURST) ? 2 : 1;
        else if (bus.cpu_req)           own = 1;
        else if (bus.vga_req)           own = 2;
        else                            own = 0;

        chk("streak", 32'(dbg_streak), m_streak);
        m_streak = (bus.cpu_req && bus.vga_req && own == 2) ? m_streak + 1 : 0;

        chk("cpu_gnt",   32'(bus.cpu_gnt),   32'(own == 1));
        chk("vga_gnt",   32'(bus.vga_gnt),   32'(own == 2));
        chk("mem_write", 32'(bus.mem_write), 32'(own == 1 && bus.cpu_write));
        if (own == 2) begin
          chk("mem_addr_vga", 32'(bus.mem_addr), 32'(bus.vga_addr));
          vga_q.push_back({32'(cyc + 1), ref_read(bus.vga_addr)});
        end else if (own == 1) begin
          chk("mem_addr_cpu", 32'(bus.mem_addr), 32'(bus.cpu_addr));
          if (bus.cpu_write) begin
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(bus.cpu_wdata));
            ref_mem[int'(bus.cpu_addr)] = bus.cpu_wdata;
          end else begin
            cpu_q.push_back({32'(cyc + 1), ref_read(bus.cpu_addr)});
          end
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic cr, input logic [15:0] ca, input logic cw,
                       input logic [15:0] cd, input logic vr, input logic [15:0] va);
    @(posedge clk);
    #1;
    bus.cpu_req   = cr;
    bus.cpu_addr  = ca;
    bus.cpu_write = cw;
    bus.cpu_wdata = cd;
    bus.vga_req   = vr;
    bus.vga_addr  = va;
  endtask

  task automatic idle();
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b0, 16'h0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    string       hist;
    logic        gc;
    logic        gv;
    int unsigned p_tab[3];
    int unsigned p;

    p_tab = '{30, 65, 97};
    rst = 1'b1;
    bus.cpu_req = 1'b0; bus.cpu_addr = 16'h0; bus.cpu_write = 1'b0; bus.cpu_wdata = 16'h0;
    bus.vga_req = 1'b0; bus.vga_addr = 16'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    idle();

    // CPU read alone
    drive(1'b1, 16'h0040, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    chk("d37_gnt",  32'(bus.cpu_gnt),  1);
    chk("d37_addr", 32'(bus.mem_addr), 32'h0040);
    idle();
    @(negedge clk);
    chk("d37_rvalid", 32'(bus.cpu_rvalid), 1);
    chk("d37_rdata",  32'(bus.cpu_rdata),  32'hBEEF);

    // CPU write, then read back
    drive(1'b1, 16'h1234, 1'b1, 16'hA5A5, 1'b0, 16'h0);
    @(negedge clk);
    chk("d38_wr",    32'(bus.mem_write), 1);
    chk("d38_wdata", 32'(bus.mem_wdata), 32'hA5A5);
    drive(1'b1, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    chk("d38_no_rvalid", 32'(bus.cpu_rvalid), 0);
    idle();
    @(negedge clk);
    chk("d38_readback", 32'(bus.cpu_rdata), 32'hA5A5);

    // Contention for 20 cycles
    idle();
    hist = "";
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 16'h0005, 1'b0, 16'h0, 1'b1, 16'h8001);
      @(negedge clk);
      if (bus.cpu_gnt && !bus.vga_gnt)      hist = {hist, "C"};
      else if (bus.vga_gnt && !bus.cpu_gnt) hist = {hist, "V"};
      else                                  hist = {hist, "-"};
    end
    n_checks++;
    if (hist != "VVVVVVVVCVVVVVVVVCVV") begin
      n_fail++;
      $display("FAIL d39_pattern: got %s expected VVVVVVVVCVVVVVVVVCVV", hist);
    end
    idle();

    // VGA then CPU back-to-back
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h8000);
    @(negedge clk);
    chk("d40_vga_gnt", 32'(bus.vga_gnt),  1);
    chk("d40_addr0",   32'(bus.mem_addr), 32'h8000);
    drive(1'b1, 16'h0010, 1'b0, 16'h0, 1'b0, 16'h0);
    @(negedge clk);
    chk("d40_cpu_gnt",    32'(bus.cpu_gnt),    1);
    chk("d40_addr1",      32'(bus.mem_addr),   32'h0010);
    chk("d40_vga_rvalid", 32'(bus.vga_rvalid), 1);
    idle();
    @(negedge clk);
    chk("d40_cpu_rvalid", 32'(bus.cpu_rvalid), 1);

    // Reset with a VGA read in flight
    drive(1'b0, 16'h0, 1'b0, 16'h0, 1'b1, 16'h8002);
    @(negedge clk);
    chk("d41_vga_gnt", 32'(bus.vga_gnt), 1);
    #1 rst = 1'b1;
    idle();
    @(negedge clk);
    chk("d41_dropped", 32'(bus.vga_rvalid), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cpu_req  = 1'b1;
    bus.cpu_addr = 16'h0003;
    @(negedge clk);
    chk("d41_cpu_first", 32'(bus.cpu_gnt),    1);
    chk("d41_no_vga",    32'(bus.vga_rvalid), 0);
    idle();

    // Idle cycles
    for (int i = 0; i < 5; i++) begin
      idle();
      @(negedge clk);
      chk("d42_gnt",    32'({bus.cpu_gnt, bus.vga_gnt}),       0);
      chk("d42_wr",     32'(bus.mem_write),                    0);
      chk("d42_rvalid", 32'({bus.cpu_rvalid, bus.vga_rvalid}), 0);
      chk("d42_streak", 32'(dbg_streak),                       0);
    end

    // Randomized traffic: requesters hold until granted
    for (int n = 0; n < 600; n++) begin
      p = p_tab[n / 200];
      @(negedge clk);
      gc = bus.cpu_gnt;
      gv = bus.vga_gnt;
      @(posedge clk);
      #1;
      if (!bus.cpu_req || gc) begin
        bus.cpu_req   = ($urandom_range(0, 99) < p);
        bus.cpu_addr  = 16'($urandom_range(0, 31));
        bus.cpu_write = ($urandom_range(0, 2) == 0);
        bus.cpu_wdata = 16'($urandom);
      end
      if (!bus.vga_req || gv) begin
        bus.vga_req  = ($urandom_range(0, 99) < p);
        bus.vga_addr = ($urandom_range(0, 1) == 0) ? 16'($urandom_range(0, 31))
                                                   : 16'(16'h8000 + $urandom_range(0, 31));
      end
    end

    repeat (3) idle();
    @(negedge clk);
    chk("drain_cpu_q", 32'(cpu_q.size()), 0);
    chk("drain_vga_q", 32'(vga_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter MAX_BURST, default 8, max consecutive VGA grants while CPU is waiting (1..15).
REQ-002 Clock  input  1  sole clock; all state updates on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 CPU_Req  input  1  CPU requests a memory access this cycle.
REQ-005 CPU_Addr  input  16  CPU word address.
REQ-006 CPU_Write  input  1  1 = write, 0 = read; valid with CPU_Req.
REQ-007 CPU_WData  input  16  CPU write data.
REQ-008 CPU_Gnt  output  1  CPU access performed this cycle.
REQ-009 CPU_RValid  output  1  CPU read data valid this cycle.
REQ-010 CPU_RData  output  16  CPU read data.
REQ-011 VGA_Req  input  1  VGA line fetcher read request (read-only requester).
REQ-012 VGA_Addr  input  16  VGA word address.
REQ-013 VGA_Gnt  output  1  VGA read performed this cycle.
REQ-014 VGA_RValid  output  1  VGA read data valid this cycle.
REQ-015 VGA_RData  output  16  VGA read data.
REQ-016 Mem_Addr  output  16  shared single-port memory address.
REQ-017 Mem_Write  output  1  memory write enable.
REQ-018 Mem_WData  output  16  memory write data.
REQ-019 Mem_RData  input  16  memory read data, valid one cycle after address presented.

Function
REQ-020 Grant decision combinational within cycle t from requests and streak counter; at most one of CPU_Gnt/VGA_Gnt high.
REQ-021 Only CPU_Req: CPU granted; streak := 0.
REQ-022 Only VGA_Req: VGA granted; streak := 0.
REQ-023 Both, streak < MAX_BURST: VGA granted; streak := streak+1.
REQ-024 Both, streak == MAX_BURST: CPU granted; streak := 0.
REQ-025 Neither: no grant; streak := 0; Mem_Write = 0.
REQ-026 Streak counter 4 bits, saturating at MAX_BURST, never wraps.
REQ-027 Mem_Addr = VGA_Addr when VGA_Gnt, else CPU_Addr.
REQ-028 Mem_Write = CPU_Gnt & CPU_Write; Mem_WData = CPU_WData always.
REQ-029 Read-tag register (NONE/CPU/VGA) loaded each edge with owner of granted read in cycle t; CPU write loads NONE.
REQ-030 CPU_RValid high in cycle t+1 iff tag == CPU; VGA_RValid iff tag == VGA; never both.
REQ-031 CPU_RData = VGA_RData = Mem_RData (pass-through); consumers qualify with RValid.
REQ-032 Read latency exactly 1 cycle from grant; back-to-back grants every cycle, no bubble, including write-after-read and port switch.
REQ-033 Requesters hold Req/Addr until Gnt seen; ungranted requests are neither dropped nor queued internally.

Reset
REQ-034 During Reset: streak = 0, tag = NONE, CPU_RValid = VGA_RValid = 0, CPU_Gnt = VGA_Gnt = 0, Mem_Write = 0.
REQ-035 Reset asserted with a read in flight discards it; no RValid after deassertion for that read.
REQ-036 First cycle after Reset deassertion arbitrates normally from streak = 0.

Verification
REQ-037 CPU read alone: CPU_Req=1, CPU_Addr=0x0040, Mem_RData=0xBEEF next cycle -> CPU_Gnt cycle t, Mem_Addr=0x0040, CPU_RValid=1 with 0xBEEF cycle t+1.
REQ-038 CPU write: CPU_Write=1, Addr=0x1234, WData=0xA5A5 -> Mem_Write=1 same cycle, Mem_WData=0xA5A5, no RValid at t+1.
REQ-039 Contention, MAX_BURST=8: both held 20 cycles -> grants VVVVVVVV C VVVVVVVV C V V; streak returns to 0 after each C.
REQ-040 Alternating: VGA reads 0x8000 then CPU read 0x0010 consecutive cycles -> VGA_RValid t+1, CPU_RValid t+2, Mem_Addr 0x8000 then 0x0010.
REQ-041 Reset mid-read: VGA granted cycle t, Reset asserted before edge t+1 -> VGA_RValid stays 0; after release streak=0, CPU alone granted first cycle.
REQ-042 Idle: no requests 5 cycles -> no grants, Mem_Write=0, both RValid=0, streak=0.
